spi_reg_responder: RTL and testbench
====================================

SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as below; their polarity and synchronicity are fixed.
REQ-002 clk_clk  in  1  system clock, at least 8x SCLK frequency.
REQ-003 reset_reset_n  in  1  asynchronous active-low reset.
REQ-004 spi_sclk  in  1  SPI clock from the HPS SPI master (spim1), mode 0 (CPOL=0, CPHA=0).
REQ-005 spi_mosi  in  1  master-out data, MSB first.
REQ-006 spi_ss_n  in  1  active-low slave select (SS0).
REQ-007 spi_miso  out  1  slave-out data.
REQ-008 spi_miso_oe  out  1  MISO output enable; 1 while selected.
REQ-009 reg_wr_en  out  1  one-cycle write strobe.
REQ-010 reg_rd_en  out  1  one-cycle read request.
REQ-011 reg_addr  out  7  register address; valid with either strobe.
REQ-012 reg_wdata  out  16  write data; valid with reg_wr_en.
REQ-013 reg_rdata  in  16  read data; sampled exactly 1 clk_clk after reg_rd_en.
REQ-014 frame_abort  out  1  one-cycle pulse when SS_n rises mid-frame.

Function
REQ-015 Synchronisation: spi_sclk, spi_mosi and spi_ss_n SHALL each pass through a 2-flop synchroniser; SCLK rise/fall and SS_n fall/rise SHALL be detected from the synchronised values.
REQ-016 Frame format: 24 bits; header byte {rw, addr[6:0]} (rw=1 is read), then 16 data bits; MOSI sampled on SCLK rise.
REQ-017 FSM states: IDLE, HDR, DATA, DONE.
- IDLE->HDR on SS_n fall; bit counter cleared.
- HDR->DATA after the 8th rise.
- DATA->DONE after the 24th rise.
- DONE->IDLE on SS_n rise.
REQ-018 Read: on the clk_clk following the 8th rise, the block SHALL pulse reg_rd_en with reg_addr; one cycle later it SHALL load reg_rdata into the TX shift register.
REQ-019 Read data transmit: the block SHALL drive reg_rdata[15] on spi_miso before the 9th rise, and shift one bit on each SCLK fall thereafter; bits 14..0 appear on rises 10..24.
REQ-020 MISO SHALL be 0 during the header, during write frames and in DONE.
REQ-021 Write: on the clk_clk following the 24th rise of a write frame, the block SHALL pulse reg_wr_en with reg_addr and reg_wdata; exactly one strobe per frame.
REQ-022 Abort: if SS_n rises in HDR or DATA, the block SHALL go to IDLE, pulse frame_abort and issue no reg_wr_en. A reg_rd_en already issued stands.
REQ-023 Overlong frame: SCLK edges in DONE SHALL be ignored; there is no second strobe.
REQ-024 SCLK edges while SS_n is high SHALL be ignored.
REQ-025 spi_miso_oe SHALL equal the inverted synchronised SS_n.
REQ-026 reg_addr and reg_wdata SHALL hold their values until the next strobe.

Reset
REQ-027 On reset assertion: FSM=IDLE; all counters and shift registers=0; all outputs 0; synchronisers preset to SCLK=0, MOSI=0, SS_n=1.
REQ-028 A frame in progress at reset assertion SHALL be discarded without strobes. After release, the block SHALL wait for a fresh SS_n fall.

Structure
REQ-029 Package spi_reg_pkg SHALL hold ADDR_W=7, DATA_W=16, FRAME_BITS=24, HDR_BITS=8, SYNC_STAGES=2 and the FSM state enum.
REQ-030 Sub-module spi_sync_edge (synchroniser plus rise/fall detector, one per input) SHALL be instantiated three times.

Verification
REQ-031 Write frame: addr 0x05, data 0xBEEF -> exactly one reg_wr_en, reg_addr=0x05, reg_wdata=0xBEEF; MISO=0 throughout.
REQ-032 Read frame: addr 0x12, responder returns 0xA55A -> one reg_rd_en with reg_addr=0x12; master captures 0xA55A.
REQ-033 Write header 0x05, SS_n released after 12 bits -> frame_abort pulses once; no reg_wr_en; next valid frame works.
REQ-034 30-SCLK write frame to 0x7F, data 0x1234 -> single reg_wr_en with data 0x1234; extra bits ignored.
REQ-035 Reset asserted at bit 16 of a write -> no strobe; outputs 0; a following write of 0x0001 to 0x00 succeeds.
REQ-036 Back-to-back frames (write 0x03=0x00FF, then read 0x03) with SS_n high for one SCLK period -> both complete; read returns the responder value.

Source files
------------

// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_pkg
//  Purpose  : Shared widths, frame geometry and FSM encoding for the SPI
//             register responder.
//  Revision : 1.0  initial release
// ============================================================================
package spi_reg_pkg;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 16;
    localparam int FRAME_BITS  = 24;
    localparam int HDR_BITS    = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Multi-flop synchroniser with rise/fall detection on the
//             synchronised value.
//  Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge
    import spi_reg_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_responder
//  Purpose  : SPI mode-0 slave decoding 24-bit {rw, addr, data} frames into
//             single-cycle register read/write strobes.
//  Revision : 1.0  initial release
// ============================================================================
module spi_reg_responder
    import spi_reg_pkg::*;
(
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_abort
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic ss_sync,   ss_rise,   ss_fall;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_clk), .rst_ni(reset_reset_n), .d_i(spi_sclk),
        .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_clk), .rst_ni(reset_reset_n), .d_i(spi_mosi),
        .sync_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall));
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
        .clk_i(clk_clk), .rst_ni(reset_reset_n), .d_i(spi_ss_n),
        .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall));

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_sync, mosi_rise, mosi_fall};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [HDR_BITS-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                ld_q, ld_d;
    logic                abort_q, abort_d;
    logic [1:0]          settle_q, settle_d;
    logic                armed_q, armed_d;
    logic [HDR_BITS-1:0] hdr_now;

    // A slave select held low across reset must not be mistaken for a new
    // frame: only arm once the synchroniser carries real, deasserted SS_n.
    localparam logic [1:0] SETTLED = 2'(SYNC_STAGES + 1);

    assign hdr_now = {shift_q[HDR_BITS-2:0], mosi_sync};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        hdr_d    = hdr_q;
        tx_d     = tx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        abort_d  = 1'b0;
        ld_d     = rd_en_q;
        settle_d = (settle_q == SETTLED) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == SETTLED) & ss_sync);

        if (ld_q) begin
            tx_d = reg_rdata;
        end

        unique case (state_q)
            IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d = HDR;
                    cnt_d   = '0;
                    shift_d = '0;
                    tx_d    = '0;
                end
            end
            HDR, DATA: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_sync};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
                        state_d = DATA;
                        hdr_d   = hdr_now;
                        if (hdr_now[HDR_BITS-1]) begin
                            rd_en_d = 1'b1;
                            addr_d  = hdr_now[ADDR_W-1:0];
                        end
                    end
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d = DONE;
                        if (!hdr_q[HDR_BITS-1]) begin
                            wr_en_d = 1'b1;
                            addr_d  = hdr_q[ADDR_W-1:0];
                            wdata_d = {shift_q[DATA_W-2:0], mosi_sync};
                        end
                    end
                end else if (sclk_fall && (state_q == DATA) && hdr_q[HDR_BITS-1]
                             && (cnt_q >= CNT_W'(HDR_BITS + 1))) begin
                    // The fall right after the header keeps bit 15 on the line.
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            hdr_q    <= '0;
            tx_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            ld_q     <= 1'b0;
            abort_q  <= 1'b0;
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            hdr_q    <= hdr_d;
            tx_q     <= tx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            ld_q     <= ld_d;
            abort_q  <= abort_d;
            settle_q <= settle_d;
            armed_q  <= armed_d;
        end
    end

    assign spi_miso    = (state_q == DATA) & hdr_q[HDR_BITS-1] & tx_q[DATA_W-1];
    assign spi_miso_oe = ~ss_sync;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_en   = rd_en_q;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign frame_abort = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_responder
//  Purpose  : Directed self-checking bench driving SPI mode-0 frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_reg_responder;

    localparam int HALF = 8;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        spi_sclk, spi_mosi, spi_ss_n;
    logic        spi_miso, spi_miso_oe;
    logic        reg_wr_en, reg_rd_en, frame_abort;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = 16'h0;

    always #5 clk_clk = ~clk_clk;

    spi_reg_responder dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .frame_abort(frame_abort));

    int checks = 0;
    int errors = 0;

    // Register-file model: rdata is valid for two cycles after the request.
    logic [15:0] mem [128];
    int          hold   = 0;
    int          wr_cnt = 0, rd_cnt = 0, ab_cnt = 0, miso_hi = 0;
    logic [6:0]  wr_addr = 7'h0, rd_addr = 7'h0;
    logic [15:0] wr_data = 16'h0;
    logic [27:0] rst_snap = 28'h0;

    always @(negedge clk_clk) begin
        if (reg_wr_en) begin
            wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; mem[reg_addr] = reg_wdata;
        end
        if (reg_rd_en) begin
            rd_cnt++; rd_addr = reg_addr; reg_rdata = mem[reg_addr]; hold = 2;
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) reg_rdata = 16'h0;
        end
        if (frame_abort) ab_cnt++;
        if (spi_miso) miso_hi++;
    end

    task automatic spi_xfer(input logic [23:0] word, input int nbits, input int rst_at,
                            input int gap, output logic [23:0] cap);
        cap = '0;
        @(negedge clk_clk);
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clk_clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset_reset_n = 1'b0;
                repeat (2) @(negedge clk_clk);
                rst_snap = {reg_wr_en, reg_rd_en, frame_abort, spi_miso, spi_miso_oe,
                            reg_addr, reg_wdata};
                reset_reset_n = 1'b1;
            end
            spi_mosi = (i < 24) ? word[23 - i] : 1'b1;
            repeat (HALF) @(negedge clk_clk);
            cap = {cap[22:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk_clk);
            spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk_clk);
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (gap) @(negedge clk_clk);
    endtask

    task automatic test_reset;
        int b_wr, b_rd;
        reset_reset_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
        repeat (4) @(negedge clk_clk);
        checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", reg_wr_en); end
        checks++; if (reg_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b expected 0", reg_rd_en); end
        checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL rst_abort: got %b expected 0", frame_abort); end
        checks++; if (reg_addr !== 7'h00) begin errors++; $display("FAIL rst_addr: got %h expected 00", reg_addr); end
        checks++; if (reg_wdata !== 16'h0000) begin errors++; $display("FAIL rst_wdata: got %h expected 0000", reg_wdata); end
        checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b expected 0", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL rst_miso_oe: got %b expected 0", spi_miso_oe); end
        reset_reset_n = 1'b1;
        repeat (6) @(negedge clk_clk);
        // SCLK toggling with SS_n high must do nothing.
        b_wr = wr_cnt; b_rd = rd_cnt;
        spi_mosi = 1'b1;
        for (int i = 0; i < 30; i++) begin
            spi_sclk = 1'b1; repeat (HALF) @(negedge clk_clk);
            spi_sclk = 1'b0; repeat (HALF) @(negedge clk_clk);
        end
        spi_mosi = 1'b0;
        checks++; if (wr_cnt - b_wr + rd_cnt - b_rd != 0) begin errors++; $display("FAIL idle_sclk_strobes: got %0d expected 0", wr_cnt - b_wr + rd_cnt - b_rd); end
    endtask

    task automatic test_write;
        logic [23:0] cap;
        int b_wr = wr_cnt, b_rd = rd_cnt, b_mh = miso_hi;
        spi_xfer(24'h05BEEF, 24, -1, 2 * HALF, cap);
        checks++; if (wr_cnt - b_wr != 1) begin errors++; $display("FAIL wr_count: got %0d expected 1", wr_cnt - b_wr); end
        checks++; if (wr_addr !== 7'h05) begin errors++; $display("FAIL wr_addr: got %h expected 05", wr_addr); end
        checks++; if (wr_data !== 16'hBEEF) begin errors++; $display("FAIL wr_data: got %h expected beef", wr_data); end
        checks++; if (rd_cnt - b_rd != 0) begin errors++; $display("FAIL wr_no_rd: got %0d expected 0", rd_cnt - b_rd); end
        checks++; if (miso_hi - b_mh != 0) begin errors++; $display("FAIL wr_miso_zero: got %0d high cycles expected 0", miso_hi - b_mh); end
        checks++; if (reg_wdata !== 16'hBEEF) begin errors++; $display("FAIL wdata_hold: got %h expected beef", reg_wdata); end
    endtask

    task automatic test_read;
        logic [23:0] cap;
        int b_wr = wr_cnt, b_rd = rd_cnt;
        spi_xfer(24'h920000, 24, -1, 2 * HALF, cap);
        checks++; if (rd_cnt - b_rd != 1) begin errors++; $display("FAIL rd_count: got %0d expected 1", rd_cnt - b_rd); end
        checks++; if (rd_addr !== 7'h12) begin errors++; $display("FAIL rd_addr: got %h expected 12", rd_addr); end
        checks++; if (cap[15:0] !== 16'hA55A) begin errors++; $display("FAIL rd_data: got %h expected a55a", cap[15:0]); end
        checks++; if (cap[23:16] !== 8'h00) begin errors++; $display("FAIL rd_hdr_miso: got %h expected 00", cap[23:16]); end
        checks++; if (wr_cnt - b_wr != 0) begin errors++; $display("FAIL rd_no_wr: got %0d expected 0", wr_cnt - b_wr); end
        checks++; if (reg_addr !== 7'h12) begin errors++; $display("FAIL rd_addr_hold: got %h expected 12", reg_addr); end
    endtask

    task automatic test_abort;
        logic [23:0] cap;
        int b_wr = wr_cnt, b_ab = ab_cnt;
        spi_xfer(24'h05ABCD, 12, -1, 2 * HALF, cap);
        checks++; if (ab_cnt - b_ab != 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", ab_cnt - b_ab); end
        checks++; if (wr_cnt - b_wr != 0) begin errors++; $display("FAIL abort_no_wr: got %0d expected 0", wr_cnt - b_wr); end
        b_ab = ab_cnt;
        spi_xfer(24'h071357, 24, -1, 2 * HALF, cap);
        checks++; if (wr_cnt - b_wr != 1) begin errors++; $display("FAIL post_abort_wr: got %0d expected 1", wr_cnt - b_wr); end
        checks++; if (wr_data !== 16'h1357 || wr_addr !== 7'h07) begin errors++; $display("FAIL post_abort_data: got %h@%h expected 1357@07", wr_data, wr_addr); end
        checks++; if (ab_cnt - b_ab != 0) begin errors++; $display("FAIL post_abort_no_abort: got %0d expected 0", ab_cnt - b_ab); end
    endtask

    task automatic test_overlong;
        logic [23:0] cap;
        int b_wr = wr_cnt, b_ab = ab_cnt;
        spi_xfer(24'h7F1234, 30, -1, 2 * HALF, cap);
        checks++; if (wr_cnt - b_wr != 1) begin errors++; $display("FAIL long_wr_count: got %0d expected 1", wr_cnt - b_wr); end
        checks++; if (wr_data !== 16'h1234) begin errors++; $display("FAIL long_wr_data: got %h expected 1234", wr_data); end
        checks++; if (wr_addr !== 7'h7F) begin errors++; $display("FAIL long_wr_addr: got %h expected 7f", wr_addr); end
        checks++; if (ab_cnt - b_ab != 0) begin errors++; $display("FAIL long_no_abort: got %0d expected 0", ab_cnt - b_ab); end
    endtask

    task automatic test_reset_mid;
        logic [23:0] cap;
        int b_wr = wr_cnt, b_rd = rd_cnt, b_ab = ab_cnt;
        spi_xfer(24'h05FFFF, 24, 16, 2 * HALF, cap);
        checks++; if (rst_snap !== 28'h0) begin errors++; $display("FAIL mid_rst_outputs: got %h expected 0000000", rst_snap); end
        checks++; if (wr_cnt - b_wr != 0) begin errors++; $display("FAIL mid_rst_no_wr: got %0d expected 0", wr_cnt - b_wr); end
        checks++; if (rd_cnt - b_rd != 0) begin errors++; $display("FAIL mid_rst_no_rd: got %0d expected 0", rd_cnt - b_rd); end
        checks++; if (ab_cnt - b_ab != 0) begin errors++; $display("FAIL mid_rst_no_abort: got %0d expected 0", ab_cnt - b_ab); end
        spi_xfer(24'h000001, 24, -1, 2 * HALF, cap);
        checks++; if (wr_cnt - b_wr != 1) begin errors++; $display("FAIL post_rst_wr: got %0d expected 1", wr_cnt - b_wr); end
        checks++; if (wr_data !== 16'h0001 || wr_addr !== 7'h00) begin errors++; $display("FAIL post_rst_data: got %h@%h expected 0001@00", wr_data, wr_addr); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] cap;
        int b_wr = wr_cnt, b_rd = rd_cnt;
        spi_xfer(24'h0300FF, 24, -1, 2 * HALF, cap);
        spi_xfer(24'h830000, 24, -1, 2 * HALF, cap);
        checks++; if (wr_cnt - b_wr != 1 || wr_data !== 16'h00FF) begin errors++; $display("FAIL b2b_wr: got %0d strobes data %h expected 1 strobe 00ff", wr_cnt - b_wr, wr_data); end
        checks++; if (rd_cnt - b_rd != 1 || rd_addr !== 7'h03) begin errors++; $display("FAIL b2b_rd: got %0d strobes addr %h expected 1 strobe 03", rd_cnt - b_rd, rd_addr); end
        checks++; if (cap[15:0] !== 16'h00FF) begin errors++; $display("FAIL b2b_rd_data: got %h expected 00ff", cap[15:0]); end
    endtask

    initial begin
        mem[7'h12] = 16'hA55A;
        test_reset;
        test_write;
        test_read;
        test_abort;
        test_overlong;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
